// File: rtl/cordic_ctrl_pkg.sv
// Shared types and constants for the Coordic request arbiter.
package cordic_ctrl_pkg;

  localparam int unsigned NUM_REQ_DEF  = 4;
  localparam int unsigned ANGLE_W_DEF  = 32;
  localparam int unsigned DATA_W_DEF   = 16;
  localparam int unsigned LOAD_CYC_DEF = 2;
  localparam int unsigned TIMEOUT_DEF  = 40;

  // Q2.30 angle: 2^30 = 90 degrees. Q2.14 data: 16384 = 1.0.
  localparam logic [31:0] ANGLE_ONE_90 = 32'h4000_0000;
  localparam logic [15:0] DATA_ONE     = 16'h4000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request after the last winner.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [IDX_W-1:0]   grant_idx_c,
  output logic               any_c
);

  logic [IDX_W-1:0] idx;

  // Scan last+1, last+2, ... ; NUM_REQ is a power of two so the add wraps.
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    any_c       = 1'b0;
    idx         = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = last + IDX_W'(k);
      if (!any_c && req[idx]) begin
        any_c        = 1'b1;
        grant_c[idx] = 1'b1;
        grant_idx_c  = idx;
      end
    end
  end

endmodule

// File: rtl/cordic_req_arbiter.sv
// Shares one Coordic engine between NUM_REQ requesters, round-robin,
// with a timeout guard and an id-tagged valid/ready response channel.
module cordic_req_arbiter
  import cordic_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_REQ  = NUM_REQ_DEF,
  parameter  int unsigned ANGLE_W  = ANGLE_W_DEF,
  parameter  int unsigned DATA_W   = DATA_W_DEF,
  parameter  int unsigned LOAD_CYC = LOAD_CYC_DEF,
  parameter  int unsigned TIMEOUT  = TIMEOUT_DEF,
  localparam int unsigned ID_W     = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*ANGLE_W-1:0] req_angle,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [ANGLE_W-1:0]         eng_angle,
  output logic                       eng_reset,
  input  logic                       eng_done,
  input  logic [DATA_W-1:0]          eng_sin,
  input  logic [DATA_W-1:0]          eng_cos,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [DATA_W-1:0]          rsp_sin,
  output logic [DATA_W-1:0]          rsp_cos,
  output logic                       rsp_err,
  output logic                       busy
);

  localparam int unsigned LCNT_W = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;
  localparam int unsigned TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t              state;
  logic [ID_W-1:0]     rr_ptr;
  logic [LCNT_W-1:0]   load_cnt;
  logic [TCNT_W-1:0]   tmo_cnt;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_any;
  logic [ANGLE_W-1:0]  sel_angle;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req         (req_valid),
    .last        (rr_ptr),
    .grant_c     (grant),
    .grant_idx_c (grant_idx),
    .any_c       (grant_any)
  );

  // Offer the grant only while idle and out of reset.
  assign req_ready = (reset && state == IDLE) ? grant : '0;

  // Angle of the current winner.
  always_comb begin
    sel_angle = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) sel_angle = req_angle[i*ANGLE_W +: ANGLE_W];
    end
  end

  // Control FSM; rr_ptr doubles as the id of the operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rr_ptr    <= ID_W'(NUM_REQ - 1);
      load_cnt  <= '0;
      tmo_cnt   <= '0;
      eng_angle <= '0;
      eng_reset <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sin   <= '0;
      rsp_cos   <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            eng_angle <= sel_angle;
            rr_ptr    <= grant_idx;
            load_cnt  <= '0;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (load_cnt == LCNT_W'(LOAD_CYC - 1)) begin
            tmo_cnt   <= '0;
            eng_reset <= 1'b0;
            state     <= RUN;
          end else begin
            load_cnt <= load_cnt + LCNT_W'(1);
          end
        end
        RUN: begin
          if (eng_done) begin
            rsp_sin   <= eng_sin;
            rsp_cos   <= eng_cos;
            rsp_err   <= 1'b0;
            rsp_id    <= rr_ptr;
            rsp_valid <= 1'b1;
            eng_reset <= 1'b1;
            state     <= RESP;
          end else if (tmo_cnt == TCNT_W'(TIMEOUT - 1)) begin
            rsp_sin   <= '0;
            rsp_cos   <= '0;
            rsp_err   <= 1'b1;
            rsp_id    <= rr_ptr;
            rsp_valid <= 1'b1;
            eng_reset <= 1'b1;
            state     <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TCNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          eng_reset <= 1'b1;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_req_arbiter.sv
// Bench for cordic_req_arbiter with a behavioural sin/cos engine model.
module tb_cordic_req_arbiter;
  import cordic_ctrl_pkg::*;

  localparam int unsigned NR      = 4;
  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 16;
  localparam int unsigned LC      = 2;
  localparam int unsigned TO      = 40;
  localparam int unsigned IW      = 2;
  localparam int unsigned ENG_CYC = 12;
  localparam int unsigned TOTAL_RSP = 14;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] s;
    logic [DW-1:0] c;
    logic          err;
  } rsp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*AW-1:0]  req_angle;
  logic [NR-1:0]     req_ready;
  logic [AW-1:0]     eng_angle;
  logic              eng_reset;
  logic              eng_done = 1'b0;
  logic [DW-1:0]     eng_sin = '0;
  logic [DW-1:0]     eng_cos = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [IW-1:0]     rsp_id;
  logic [DW-1:0]     rsp_sin;
  logic [DW-1:0]     rsp_cos;
  logic              rsp_err;
  logic              busy;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_rsp   = 0;
  int   cyc     = 0;
  int   grant_cyc = 0;
  int   r1_cnt  = 0;
  int   pending [NR];
  int   glog [$];
  rsp_t exp_q [$];
  bit   never_done = 1'b0;

  logic [AW-1:0] eng_lat = '0;
  int            eng_cnt = 0;

  cordic_req_arbiter #(
    .NUM_REQ (NR), .ANGLE_W (AW), .DATA_W (DW), .LOAD_CYC (LC), .TIMEOUT (TO)
  ) dut (
    .clk (clk), .reset (reset),
    .req_valid (req_valid), .req_angle (req_angle), .req_ready (req_ready),
    .eng_angle (eng_angle), .eng_reset (eng_reset), .eng_done (eng_done),
    .eng_sin (eng_sin), .eng_cos (eng_cos),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_id (rsp_id),
    .rsp_sin (rsp_sin), .rsp_cos (rsp_cos), .rsp_err (rsp_err), .busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Requester angles: 30, 45, -45, 90 degrees.
  initial req_angle = {ANGLE_ONE_90, 32'hE000_0000, 32'h2000_0000, 32'h1555_5555};

  // Hand-derived Q2.14 results for each requester's angle.
  function automatic rsp_t exp_rsp(input int id);
    rsp_t e;
    e.id  = IW'(id);
    e.err = 1'b0;
    case (id)
      0:       begin e.s = 16'h2000; e.c = 16'h376D; end
      1:       begin e.s = 16'h2D41; e.c = 16'h2D41; end
      2:       begin e.s = 16'hD2BF; e.c = 16'h2D41; end
      default: begin e.s = DATA_ONE; e.c = 16'h0000; end
    endcase
    return e;
  endfunction

  function automatic logic [15:0] to_q14(input real v);
    real s;
    s = v * 16384.0;
    return 16'($rtoi(s >= 0.0 ? s + 0.5 : s - 0.5));
  endfunction

  function automatic real to_rad(input logic [31:0] a);
    return $itor($signed(a)) * (1.5707963267948966 / 1073741824.0);
  endfunction

  // Engine model: loads while held, reports done ENG_CYC cycles into the run.
  always @(posedge clk) begin
    if (eng_reset) begin
      eng_cnt  <= 0;
      eng_done <= 1'b0;
      eng_lat  <= eng_angle;
    end else if (!never_done) begin
      eng_cnt <= eng_cnt + 1;
      if (eng_cnt == ENG_CYC - 1) begin
        eng_done <= 1'b1;
        eng_sin  <= to_q14($sin(to_rad(eng_lat)));
        eng_cos  <= to_q14($cos(to_rad(eng_lat)));
      end
    end
  end

  // Requesters: hold valid while work is pending, log every accepted grant.
  initial begin : requesters
    logic [NR-1:0] g;
    for (int i = 0; i < NR; i++) pending[i] = 0;
    forever begin
      @(negedge clk);
      g = req_valid & req_ready;
      if (req_ready[1]) r1_cnt++;
      if (g != '0) begin
        check_eq("grant_onehot", $countones(g), 1);
        for (int i = 0; i < NR; i++) if (g[i]) glog.push_back(i);
        grant_cyc = cyc;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) if (g[i] && pending[i] > 0) pending[i]--;
      #1;
      for (int i = 0; i < NR; i++) req_valid[i] = (pending[i] > 0);
    end
  end

  // Response scoreboard.
  initial begin : rsp_monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        if (exp_q.size() == 0) begin
          check_eq("rsp_unexpected", 32'(rsp_id), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check_eq("rsp_id",  32'(rsp_id),  32'(e.id));
          check_eq("rsp_sin", 32'(rsp_sin), 32'(e.s));
          check_eq("rsp_cos", 32'(rsp_cos), 32'(e.c));
          check_eq("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
  end

  task automatic set_rsp_ready(input logic v);
    @(posedge clk);
    #1 rsp_ready = v;
  endtask

  task automatic wait_empty(input string tag, input int bound);
    bit done_ok;
    done_ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !rsp_valid) begin
        done_ok = 1'b1;
        break;
      end
    end
    if (!done_ok) check_eq(tag, 32'(exp_q.size()), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_eng_reset"}, 32'(eng_reset), 1);
    check_eq({tag, "_eng_angle"}, eng_angle, 0);
    check_eq({tag, "_req_ready"}, 32'(req_ready), 0);
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check_eq({tag, "_rsp_id"},    32'(rsp_id), 0);
    check_eq({tag, "_rsp_sin"},   32'(rsp_sin), 0);
    check_eq({tag, "_rsp_cos"},   32'(rsp_cos), 0);
    check_eq({tag, "_rsp_err"},   32'(rsp_err), 0);
    check_eq({tag, "_busy"},      32'(busy), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int order_rr [5] = '{0, 1, 2, 3, 0};
    int order_hd [3] = '{1, 2, 3};
    rsp_t e;
    bit seen;

    // Reset values
    #2 reset = 1'b0;
    #5 check_reset_values("por");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // All four requesters held valid: order 0,1,2,3,0
    glog.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(exp_rsp(order_rr[i]));
    pending[0] = 2; pending[1] = 1; pending[2] = 1; pending[3] = 1;
    wait_empty("rr_drain", 500);
    check_eq("rr_count", 32'(glog.size()), 5);
    for (int i = 0; i < 5; i++)
      check_eq("rr_order", (i < glog.size()) ? glog[i] : 99, order_rr[i]);

    // Requester 1 alone at 45 deg; hold its response while 2 and 3 wait
    set_rsp_ready(1'b0);
    glog.delete();
    r1_cnt = 0;
    exp_q.push_back(exp_rsp(1));
    pending[1] = 1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1'b1; break; end
    end
    check_eq("hold_rsp_seen", 32'(seen), 1);
    pending[2] = 1; pending[3] = 1;
    exp_q.push_back(exp_rsp(2));
    exp_q.push_back(exp_rsp(3));
    e = exp_rsp(1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("hold_valid", 32'(rsp_valid), 1);
      check_eq("hold_id",    32'(rsp_id),    32'(e.id));
      check_eq("hold_sin",   32'(rsp_sin),   32'(e.s));
      check_eq("hold_cos",   32'(rsp_cos),   32'(e.c));
      check_eq("hold_err",   32'(rsp_err),   0);
      check_eq("hold_ready", 32'(req_ready), 0);
    end
    set_rsp_ready(1'b1);
    wait_empty("hold_drain", 300);
    check_eq("r1_ready_cycles", r1_cnt, 1);
    check_eq("hold_count", 32'(glog.size()), 3);
    for (int i = 0; i < 3; i++)
      check_eq("hold_order", (i < glog.size()) ? glog[i] : 99, order_hd[i]);

    // Requester 0 alone at 30 deg
    exp_q.push_back(exp_rsp(0));
    pending[0] = 1;
    wait_empty("r0_drain", 200);

    // Engine never finishes: timeout response with zeroed data
    never_done = 1'b1;
    e = '{id: 2'd3, s: 16'h0, c: 16'h0, err: 1'b1};
    exp_q.push_back(e);
    pending[3] = 1;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1'b1; break; end
    end
    check_eq("tmo_seen", 32'(seen), 1);
    check_eq("tmo_latency", cyc - grant_cyc, 1 + LC + TO);
    wait_empty("tmo_drain", 50);
    never_done = 1'b0;

    // Reset mid-RUN discards the operation; pointer restarts at NUM_REQ-1
    pending[2] = 1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy && !eng_reset) begin seen = 1'b1; break; end
    end
    check_eq("rst_run_seen", 32'(seen), 1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_reset_values("mid");
    for (int i = 0; i < NR; i++) pending[i] = 1;
    repeat (3) @(negedge clk);
    check_reset_values("held");
    glog.delete();
    for (int i = 0; i < NR; i++) exp_q.push_back(exp_rsp(i));
    reset = 1'b1;
    wait_empty("post_rst_drain", 400);
    check_eq("post_rst_first", (glog.size() > 0) ? glog[0] : 99, 0);
    repeat (40) @(negedge clk);
    check_eq("rsp_total", n_rsp, TOTAL_RSP);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
